tensorcore_kloop_ctrl: RTL and testbench

//  Sequences the 4x4x8 FP8 tensorcore across a long reduction: D = A(4xK)*B(Kx4) + C, with K = 8*k_chunks.

---
 rtl/tensorcore_kloop_ctrl.sv | 174 +++++++++++++++++
 tb/tb_tensorcore_kloop_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tensorcore_kloop_ctrl.sv
// rtl/tensorcore_kloop_ctrl.sv - K-loop sequencer for the 4x4x8 FP8 tensorcore
//
// Purpose:
//   Runs D = A(4xK) * B(Kx4) + C with K = 8*kchunks on a single 4x4x8 tensorcore.
//   Each step fetches one 8-deep A/B chunk and issues it with the running
//   accumulator as C. The step's FP16 result becomes the next step's C. The
//   final tile is returned on a valid/ready result port. Only one command is
//   in flight at a time. No arithmetic is done here.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   cmd_valid/cmd_ready      command handshake (ready only in IDLE)
//   cmd_kchunks/e5m2/c       chunk count (0 legal), FP8 format, initial C tile
//   chunk_req/idx/ack/a/b    operand chunk fetch (ack only honoured while req)
//   tc_in_valid, tc_e5m2,
//   tc_a/tc_b/tc_c           issue pulse and operands, held through WAIT
//   tc_out_valid, tc_d       tensorcore result
//   res_valid/ready/d/err    final tile; err=1 means aborted on timeout
//   busy                     FSM not in IDLE
`timescale 1ns/1ps
module tensorcore_kloop_ctrl #(
   parameter int KCHUNK_W    = 8,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [KCHUNK_W-1:0] cmd_kchunks,
   input  logic                cmd_e5m2,
   input  logic [255:0]        cmd_c,
   output logic                chunk_req,
   output logic [KCHUNK_W-1:0] chunk_idx,
   input  logic                chunk_ack,
   input  logic [255:0]        chunk_a,
   input  logic [255:0]        chunk_b,
   output logic                tc_in_valid,
   output logic                tc_e5m2,
   output logic [255:0]        tc_a,
   output logic [255:0]        tc_b,
   output logic [255:0]        tc_c,
   input  logic                tc_out_valid,
   input  logic [255:0]        tc_d,
   output logic                res_valid,
   input  logic                res_ready,
   output logic [255:0]        res_d,
   output logic                res_err,
   output logic                busy
);

   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_ISSUE,
      S_WAIT,
      S_DONE
   } state_t;

   state_t              state_q, state_d;
   logic [KCHUNK_W-1:0] kchunks_q, kchunks_d;
   logic [KCHUNK_W-1:0] chunk_idx_q, chunk_idx_d;
   logic                e5m2_q, e5m2_d;
   logic [255:0]        acc_q, acc_d;
   logic [255:0]        tc_a_q, tc_a_d;
   logic [255:0]        tc_b_q, tc_b_d;
   logic [255:0]        tc_c_q, tc_c_d;
   logic [CNT_W-1:0]    wait_cnt_q, wait_cnt_d;
   logic                res_err_q, res_err_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         kchunks_q   <= '0;
         chunk_idx_q <= '0;
         e5m2_q      <= 1'b0;
         acc_q       <= '0;
         tc_a_q      <= '0;
         tc_b_q      <= '0;
         tc_c_q      <= '0;
         wait_cnt_q  <= '0;
         res_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         kchunks_q   <= kchunks_d;
         chunk_idx_q <= chunk_idx_d;
         e5m2_q      <= e5m2_d;
         acc_q       <= acc_d;
         tc_a_q      <= tc_a_d;
         tc_b_q      <= tc_b_d;
         tc_c_q      <= tc_c_d;
         wait_cnt_q  <= wait_cnt_d;
         res_err_q   <= res_err_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      kchunks_d   = kchunks_q;
      chunk_idx_d = chunk_idx_q;
      e5m2_d      = e5m2_q;
      acc_d       = acc_q;
      tc_a_d      = tc_a_q;
      tc_b_d      = tc_b_q;
      tc_c_d      = tc_c_q;
      wait_cnt_d  = wait_cnt_q;
      res_err_d   = res_err_q;

      case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               kchunks_d   = cmd_kchunks;
               e5m2_d      = cmd_e5m2;
               acc_d       = cmd_c;
               chunk_idx_d = '0;
               // An empty reduction returns C untouched without using the tensorcore.
               state_d     = (cmd_kchunks == '0) ? S_DONE : S_FETCH;
            end
         end
         S_FETCH: begin
            if (chunk_ack) begin
               tc_a_d  = chunk_a;
               tc_b_d  = chunk_b;
               tc_c_d  = acc_q;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            wait_cnt_d = '0;
            state_d    = S_WAIT;
         end
         S_WAIT: begin
            // A result arriving on the timeout cycle still counts as success.
            if (tc_out_valid) begin
               acc_d = tc_d;
               if (chunk_idx_q == kchunks_q - KCHUNK_W'(1)) begin
                  state_d = S_DONE;
               end else begin
                  chunk_idx_d = chunk_idx_q + KCHUNK_W'(1);
                  state_d     = S_FETCH;
               end
            end else if (wait_cnt_q == CNT_LAST) begin
               res_err_d = 1'b1;
               state_d   = S_DONE;
            end else begin
               wait_cnt_d = wait_cnt_q + CNT_W'(1);
            end
         end
         S_DONE: begin
            if (res_ready) begin
               res_err_d = 1'b0;
               state_d   = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign cmd_ready   = (state_q == S_IDLE);
   assign chunk_req   = (state_q == S_FETCH);
   assign chunk_idx   = chunk_idx_q;
   assign tc_in_valid = (state_q == S_ISSUE);
   assign tc_e5m2     = e5m2_q;
   assign tc_a        = tc_a_q;
   assign tc_b        = tc_b_q;
   assign tc_c        = tc_c_q;
   assign res_valid   = (state_q == S_DONE);
   assign res_d       = acc_q;
   assign res_err     = res_err_q;
   assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_tensorcore_kloop_ctrl.sv
// tb/tb_tensorcore_kloop_ctrl.sv - directed self-checking bench for tensorcore_kloop_ctrl
`timescale 1ns/1ps
module tb_tensorcore_kloop_ctrl;

   localparam int KW       = 8;
   localparam int STUB_LAT = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [KW-1:0] cmd_kchunks;
   logic          cmd_e5m2;
   logic [255:0]  cmd_c;
   logic          chunk_req;
   logic [KW-1:0] chunk_idx;
   logic          chunk_ack;
   logic [255:0]  chunk_a;
   logic [255:0]  chunk_b;
   logic          tc_in_valid;
   logic          tc_e5m2;
   logic [255:0]  tc_a;
   logic [255:0]  tc_b;
   logic [255:0]  tc_c;
   logic          tc_out_valid;
   logic [255:0]  tc_d;
   logic          res_valid;
   logic          res_ready;
   logic [255:0]  res_d;
   logic          res_err;
   logic          busy;

   tensorcore_kloop_ctrl #(.KCHUNK_W(KW), .TIMEOUT_CYC(64)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_kchunks(cmd_kchunks),
      .cmd_e5m2(cmd_e5m2), .cmd_c(cmd_c),
      .chunk_req(chunk_req), .chunk_idx(chunk_idx), .chunk_ack(chunk_ack),
      .chunk_a(chunk_a), .chunk_b(chunk_b),
      .tc_in_valid(tc_in_valid), .tc_e5m2(tc_e5m2), .tc_a(tc_a), .tc_b(tc_b), .tc_c(tc_c),
      .tc_out_valid(tc_out_valid), .tc_d(tc_d),
      .res_valid(res_valid), .res_ready(res_ready), .res_d(res_d), .res_err(res_err),
      .busy(busy)
   );

   always #5 clk = ~clk;

   localparam logic [255:0] ONES_FP8 = {32{8'h38}};

   int n_checks = 0;
   int n_pass   = 0;
   int cyc_n    = 0;
   int stub_cnt = 0;
   bit stub_en  = 1'b1;
   int ack_delay, ack_cnt, exp_idx, idx_bad, ready_bad, stable_bad;
   int n_issue, n_req_cyc, issue_cyc, res_cyc, res_at;
   logic [255:0] last_issue_a, last_issue_b, last_issue_c, res_got;
   logic         last_issue_e5, err_got;

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   // Tensorcore stand-in for all-1.0 operands: each element of D is C + 8.0.
   function automatic logic [255:0] plus8(input logic [255:0] c);
      logic [255:0] r;
      for (int i = 0; i < 16; i++) begin
         case (c[16*i +: 16])
            16'h0000: r[16*i +: 16] = 16'h4800;
            16'h3C00: r[16*i +: 16] = 16'h4880;
            16'h4880: r[16*i +: 16] = 16'h4C40;
            16'h4800: r[16*i +: 16] = 16'h4C00;
            16'h4C00: r[16*i +: 16] = 16'h4E00;
            default:  r[16*i +: 16] = 16'hDEAD;
         endcase
      end
      return r;
   endfunction

   // One clock: sample just after the edge, then play operand buffer and tensorcore.
   task automatic tick();
      @(posedge clk);
      #1;
      cyc_n++;
      tc_out_valid = 1'b0;
      chunk_ack    = 1'b0;
      if (stub_cnt > 0) begin
         stub_cnt--;
         if (stub_cnt == 0) begin
            tc_out_valid = 1'b1;
            tc_d         = plus8(tc_c);
         end
      end
      if (tc_in_valid) begin
         n_issue++;
         issue_cyc     = cyc_n;
         last_issue_a  = tc_a;
         last_issue_b  = tc_b;
         last_issue_c  = tc_c;
         last_issue_e5 = tc_e5m2;
         if (stub_en) stub_cnt = STUB_LAT;
      end
      if (chunk_req) begin
         n_req_cyc++;
         if (chunk_idx != KW'(exp_idx)) idx_bad++;
         if (ack_cnt == ack_delay) begin
            chunk_ack = 1'b1;
            ack_cnt   = 0;
            exp_idx++;
         end else begin
            ack_cnt++;
         end
      end
      if (busy && cmd_ready) ready_bad++;
   endtask

   task automatic run_cmd(input int k, input logic [15:0] c16, input logic e5,
                          input int ack_dly, input int rdy_dly, input bit stub_on);
      int t0;
      int guard;
      n_issue = 0; n_req_cyc = 0; exp_idx = 0; idx_bad = 0; ready_bad = 0;
      stable_bad = 0; ack_cnt = 0; ack_delay = ack_dly; stub_en = stub_on;
      cmd_kchunks = KW'(k);
      cmd_c       = {16{c16}};
      cmd_e5m2    = e5;
      cmd_valid   = 1'b1;
      t0 = cyc_n;
      tick();
      cmd_valid = 1'b0;
      guard = 0;
      while (!res_valid && guard < 1000) begin
         tick();
         guard++;
      end
      res_cyc = cyc_n - t0 + 1;
      res_at  = cyc_n;
      check("res_valid_seen", res_valid, 1'b1);
      res_got = res_d;
      err_got = res_err;
      for (int i = 0; i < rdy_dly; i++) begin
         tick();
         if (res_valid !== 1'b1 || res_d !== res_got || res_err !== err_got || cmd_ready !== 1'b0)
            stable_bad++;
      end
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      check("post_xfer {valid,err,busy,cmd_ready}", {res_valid, res_err, busy, cmd_ready}, 4'b0001);
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, " ctl {cmd_ready,req,tc_in,res_valid,err,busy,e5m2}"},
            {cmd_ready, chunk_req, tc_in_valid, res_valid, res_err, busy, tc_e5m2}, 7'b1000000);
      check({tag, " chunk_idx"}, chunk_idx, '0);
      check({tag, " tc_a|tc_b|tc_c"}, tc_a | tc_b | tc_c, '0);
      check({tag, " res_d"}, res_d, '0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      int guard;
      rst = 1'b1; cmd_valid = 1'b0; cmd_kchunks = '0; cmd_e5m2 = 1'b0; cmd_c = '0;
      chunk_ack = 1'b0; chunk_a = ONES_FP8; chunk_b = ONES_FP8;
      tc_out_valid = 1'b0; tc_d = '0; res_ready = 1'b0;
      ack_delay = 0; ack_cnt = 0; exp_idx = 0;
      tick();
      tick();
      check_reset_state("reset");
      rst = 1'b0;
      tick();

      // 1: single chunk, C = 0 -> 8.0
      run_cmd(1, 16'h0000, 1'b0, 0, 0, 1'b1);
      check("t1 res_d", res_got, {16{16'h4800}});
      check("t1 res_err", err_got, 1'b0);
      check("t1 issues", n_issue, 1);
      check("t1 issued a,b", {last_issue_a, last_issue_b}, {ONES_FP8, ONES_FP8});
      check("t1 tc_e5m2", last_issue_e5, 1'b0);

      // 2: two chunks, C = 1.0 -> 9.0 fed back -> 17.0
      run_cmd(2, 16'h3C00, 1'b0, 0, 0, 1'b1);
      check("t2 issues", n_issue, 2);
      check("t2 second tc_c", last_issue_c, {16{16'h4880}});
      check("t2 res_d", res_got, {16{16'h4C40}});
      check("t2 chunk_idx seq", idx_bad, 0);

      // 3: zero chunks returns C without touching the tensorcore
      run_cmd(0, 16'h4000, 1'b0, 0, 0, 1'b1);
      check("t3 chunk_req cycles", n_req_cyc, 0);
      check("t3 issues", n_issue, 0);
      check("t3 res_valid cycle", res_cyc, 2);
      check("t3 res_d", res_got, {16{16'h4000}});

      // 4: tensorcore never answers -> abort after 64 WAIT cycles, acc unchanged
      run_cmd(1, 16'h4000, 1'b0, 0, 0, 1'b0);
      check("t4 res_err", err_got, 1'b1);
      check("t4 wait cycles", res_at - issue_cyc - 1, 64);
      check("t4 res_d", res_got, {16{16'h4000}});
      run_cmd(1, 16'h0000, 1'b0, 0, 0, 1'b1);
      check("t4 next res_d", res_got, {16{16'h4800}});
      check("t4 next res_err", err_got, 1'b0);

      // 5: slow operand buffer and slow result consumer
      run_cmd(1, 16'h0000, 1'b0, 5, 10, 1'b1);
      check("t5 chunk_req cycles", n_req_cyc, 6);
      check("t5 result stable", stable_bad, 0);
      check("t5 cmd_ready while busy", ready_bad, 0);
      check("t5 res_d", res_got, {16{16'h4800}});

      // 6: reset mid-WAIT of a k=4 command, then a stale tc_out_valid
      n_issue = 0; ack_delay = 0; ack_cnt = 0; exp_idx = 0; stub_en = 1'b1;
      cmd_kchunks = KW'(4); cmd_c = '0; cmd_e5m2 = 1'b1; cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      guard = 0;
      while (n_issue == 0 && guard < 50) begin
         tick();
         guard++;
      end
      check("t6 issued", n_issue, 1);
      check("t6 tc_e5m2 latched", last_issue_e5, 1'b1);
      tick();
      check("t6 in WAIT busy", busy, 1'b1);
      rst = 1'b1;
      tick();
      check_reset_state("t6 after rst");
      rst = 1'b0;
      tick();
      check("t6 stale tc_out_valid driven", tc_out_valid, 1'b1);
      tick();
      check("t6 stale ignored {busy,cmd_ready}", {busy, cmd_ready}, 2'b01);
      check("t6 stale ignored res_d", res_d, '0);
      run_cmd(1, 16'h0000, 1'b0, 0, 0, 1'b1);
      check("t6 fresh res_d", res_got, {16{16'h4800}});
      check("t6 fresh res_err", err_got, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
